flu_extract_arb: RTL and testbench

FLU_EXTRACT_ARB -- requirements
Module: flu_extract_arb

---
 rtl/flu_extract_arb.sv | 242 ++++++++++++++++++++++++
 tb/tb_flu_extract_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flu_extract_arb.sv
// Two-input FLU arbiter working at packet granularity: one port owns the output
// until its packet ends, words pass through one register stage with the packet offset.
module flu_extract_arb #(
    parameter int DATA_WIDTH    = 512,
    parameter int SOP_POS_WIDTH = 3,
    parameter int EOP_POS_WIDTH = $clog2(DATA_WIDTH/8),
    parameter int OFFSET_WIDTH  = 10
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_WIDTH-1:0]    RX0_DATA,
    input  logic [SOP_POS_WIDTH-1:0] RX0_SOP_POS,
    input  logic [EOP_POS_WIDTH-1:0] RX0_EOP_POS,
    input  logic                     RX0_SOP,
    input  logic                     RX0_EOP,
    input  logic                     RX0_SRC_RDY,
    output logic                     RX0_DST_RDY,
    input  logic [OFFSET_WIDTH-1:0]  RX0_OFFSET,
    input  logic [DATA_WIDTH-1:0]    RX1_DATA,
    input  logic [SOP_POS_WIDTH-1:0] RX1_SOP_POS,
    input  logic [EOP_POS_WIDTH-1:0] RX1_EOP_POS,
    input  logic                     RX1_SOP,
    input  logic                     RX1_EOP,
    input  logic                     RX1_SRC_RDY,
    output logic                     RX1_DST_RDY,
    input  logic [OFFSET_WIDTH-1:0]  RX1_OFFSET,
    output logic [DATA_WIDTH-1:0]    TX_DATA,
    output logic [SOP_POS_WIDTH-1:0] TX_SOP_POS,
    output logic [EOP_POS_WIDTH-1:0] TX_EOP_POS,
    output logic                     TX_SOP,
    output logic                     TX_EOP,
    output logic                     TX_SRC_RDY,
    input  logic                     TX_DST_RDY,
    output logic [OFFSET_WIDTH-1:0]  TX_OFFSET,
    output logic                     TX_PORT
);

    // log2 of the SOP block size in bytes
    localparam int BLK_LOG = EOP_POS_WIDTH - SOP_POS_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      last_q, last_d;
    logic                      out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]     tx_data_q, tx_data_d;
    logic [SOP_POS_WIDTH-1:0]  tx_sop_pos_q, tx_sop_pos_d;
    logic [EOP_POS_WIDTH-1:0]  tx_eop_pos_q, tx_eop_pos_d;
    logic                      tx_sop_q, tx_sop_d;
    logic                      tx_eop_q, tx_eop_d;
    logic [OFFSET_WIDTH-1:0]   tx_offset_q, tx_offset_d;
    logic                      tx_port_q, tx_port_d;

    logic                      req0_s, req1_s;
    logic                      dst_rdy0_s, dst_rdy1_s;
    logic                      fire0_s, fire1_s, fire_s;
    logic                      release_s;
    logic [DATA_WIDTH-1:0]     in_data_s;
    logic [SOP_POS_WIDTH-1:0]  in_sop_pos_s;
    logic [EOP_POS_WIDTH-1:0]  in_eop_pos_s;
    logic                      in_sop_s, in_eop_s;
    logic [OFFSET_WIDTH-1:0]   in_offset_s;

    // A word with EOP closes the lock unless a new packet starts after the EOP byte
    function automatic logic ends_packet(input logic                     sop,
                                         input logic                     eop,
                                         input logic [SOP_POS_WIDTH-1:0] sop_pos,
                                         input logic [EOP_POS_WIDTH-1:0] eop_pos);
        logic [EOP_POS_WIDTH-1:0] sop_byte;
        sop_byte = EOP_POS_WIDTH'(sop_pos) << BLK_LOG;
        return eop & (~sop | (sop_byte <= eop_pos));
    endfunction

    assign req0_s    = RX0_SRC_RDY & RX0_SOP;
    assign req1_s    = RX1_SRC_RDY & RX1_SOP;
    assign fire0_s   = RX0_SRC_RDY & dst_rdy0_s;
    assign fire1_s   = RX1_SRC_RDY & dst_rdy1_s;
    assign fire_s    = fire0_s | fire1_s;
    assign release_s = ends_packet(in_sop_s, in_eop_s, in_sop_pos_s, in_eop_pos_s);

    // Input word of the port currently holding the lock
    always_comb begin
        if (state_q == LOCK1) begin
            in_data_s    = RX1_DATA;
            in_sop_pos_s = RX1_SOP_POS;
            in_eop_pos_s = RX1_EOP_POS;
            in_sop_s     = RX1_SOP;
            in_eop_s     = RX1_EOP;
            in_offset_s  = RX1_OFFSET;
        end else begin
            in_data_s    = RX0_DATA;
            in_sop_pos_s = RX0_SOP_POS;
            in_eop_pos_s = RX0_EOP_POS;
            in_sop_s     = RX0_SOP;
            in_eop_s     = RX0_EOP;
            in_offset_s  = RX0_OFFSET;
        end
    end

    // FSM state and tie-break register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant in IDLE, hold the lock until the packet closes
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0_s && req1_s) begin
                    if (last_q) begin
                        state_d = LOCK0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = LOCK1;
                        last_d  = 1'b1;
                    end
                end else if (req0_s) begin
                    state_d = LOCK0;
                    last_d  = 1'b0;
                end else if (req1_s) begin
                    state_d = LOCK1;
                    last_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK0: begin
                if (fire0_s && release_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK0;
                end
            end
            LOCK1: begin
                if (fire1_s && release_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs: only the owner may transfer, and only when the output stage frees up
    always_comb begin
        dst_rdy0_s = 1'b0;
        dst_rdy1_s = 1'b0;
        if (RESET) begin
            dst_rdy0_s = 1'b0;
            dst_rdy1_s = 1'b0;
        end else begin
            case (state_q)
                LOCK0:   dst_rdy0_s = ~out_valid_q | TX_DST_RDY;
                LOCK1:   dst_rdy1_s = ~out_valid_q | TX_DST_RDY;
                default: begin
                    dst_rdy0_s = 1'b0;
                    dst_rdy1_s = 1'b0;
                end
            endcase
        end
    end

    // Output stage next values: load on transfer, drain on acceptance, else hold
    always_comb begin
        out_valid_d  = out_valid_q;
        tx_data_d    = tx_data_q;
        tx_sop_pos_d = tx_sop_pos_q;
        tx_eop_pos_d = tx_eop_pos_q;
        tx_sop_d     = tx_sop_q;
        tx_eop_d     = tx_eop_q;
        tx_offset_d  = tx_offset_q;
        tx_port_d    = tx_port_q;
        if (fire_s) begin
            out_valid_d  = 1'b1;
            tx_data_d    = in_data_s;
            tx_sop_pos_d = in_sop_pos_s;
            tx_eop_pos_d = in_eop_pos_s;
            tx_sop_d     = in_sop_s;
            tx_eop_d     = in_eop_s;
            tx_port_d    = fire1_s;
            if (in_sop_s) begin
                tx_offset_d = in_offset_s;
            end else begin
                tx_offset_d = tx_offset_q;
            end
        end else if (TX_DST_RDY) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid_q  <= 1'b0;
            tx_data_q    <= '0;
            tx_sop_pos_q <= '0;
            tx_eop_pos_q <= '0;
            tx_sop_q     <= 1'b0;
            tx_eop_q     <= 1'b0;
            tx_offset_q  <= '0;
            tx_port_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            tx_data_q    <= tx_data_d;
            tx_sop_pos_q <= tx_sop_pos_d;
            tx_eop_pos_q <= tx_eop_pos_d;
            tx_sop_q     <= tx_sop_d;
            tx_eop_q     <= tx_eop_d;
            tx_offset_q  <= tx_offset_d;
            tx_port_q    <= tx_port_d;
        end
    end

    assign RX0_DST_RDY = dst_rdy0_s;
    assign RX1_DST_RDY = dst_rdy1_s;
    assign TX_SRC_RDY  = out_valid_q & ~RESET;
    assign TX_DATA     = tx_data_q;
    assign TX_SOP_POS  = tx_sop_pos_q;
    assign TX_EOP_POS  = tx_eop_pos_q;
    assign TX_SOP      = tx_sop_q;
    assign TX_EOP      = tx_eop_q;
    assign TX_OFFSET   = tx_offset_q;
    assign TX_PORT     = tx_port_q;

endmodule

// File: tb/tb_flu_extract_arb.sv
// Bench for flu_extract_arb: directed arbitration scenarios plus randomized traffic
// checked against per-port scoreboards and a packet-level ownership model.
module tb_flu_extract_arb;

    localparam int DW  = 512;
    localparam int SPW = 3;
    localparam int EPW = 6;
    localparam int OW  = 10;

    typedef struct {
        logic [DW-1:0]  data;
        logic [SPW-1:0] sop_pos;
        logic [EPW-1:0] eop_pos;
        logic           sop;
        logic           eop;
        logic [OW-1:0]  off;
    } word_t;

    logic           clk;
    logic           rst;
    logic [DW-1:0]  rx_data    [2];
    logic [SPW-1:0] rx_sop_pos [2];
    logic [EPW-1:0] rx_eop_pos [2];
    logic           rx_sop     [2];
    logic           rx_eop     [2];
    logic           rx_src_rdy [2];
    logic           rx_dst_rdy [2];
    logic [OW-1:0]  rx_off     [2];
    logic [DW-1:0]  tx_data;
    logic [SPW-1:0] tx_sop_pos;
    logic [EPW-1:0] tx_eop_pos;
    logic           tx_sop, tx_eop, tx_src_rdy, tx_dst_rdy, tx_port;
    logic [OW-1:0]  tx_offset;

    flu_extract_arb dut (
        .CLK(clk), .RESET(rst),
        .RX0_DATA(rx_data[0]), .RX0_SOP_POS(rx_sop_pos[0]), .RX0_EOP_POS(rx_eop_pos[0]),
        .RX0_SOP(rx_sop[0]), .RX0_EOP(rx_eop[0]), .RX0_SRC_RDY(rx_src_rdy[0]),
        .RX0_DST_RDY(rx_dst_rdy[0]), .RX0_OFFSET(rx_off[0]),
        .RX1_DATA(rx_data[1]), .RX1_SOP_POS(rx_sop_pos[1]), .RX1_EOP_POS(rx_eop_pos[1]),
        .RX1_SOP(rx_sop[1]), .RX1_EOP(rx_eop[1]), .RX1_SRC_RDY(rx_src_rdy[1]),
        .RX1_DST_RDY(rx_dst_rdy[1]), .RX1_OFFSET(rx_off[1]),
        .TX_DATA(tx_data), .TX_SOP_POS(tx_sop_pos), .TX_EOP_POS(tx_eop_pos),
        .TX_SOP(tx_sop), .TX_EOP(tx_eop), .TX_SRC_RDY(tx_src_rdy),
        .TX_DST_RDY(tx_dst_rdy), .TX_OFFSET(tx_offset), .TX_PORT(tx_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    word_t         src_q [2][$];
    word_t         sb_q  [2][$];
    logic [OW-1:0] last_off [2];
    int            in_cnt [2];
    int            out_cnt [2];
    int            tx_ports [$];
    int            tx_offs  [$];
    bit            en [2];
    bit            rand_en   = 1'b0;
    bit            rand_rdy  = 1'b0;
    bit            pend_valid = 1'b0;
    int            pend_port  = 0;
    bit            prev_stall = 1'b0;
    bit            post_rst   = 1'b0;
    int            tx_open    = -1;
    logic [DW-1:0] snap_data;
    logic [DW-1:0] snap_ctrl;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk(input logic s, input int sp, input logic e, input int ep, input int off);
        word_t w;
        for (int i = 0; i < DW/32; i++) w.data[i*32 +: 32] = $urandom();
        w.sop = s; w.sop_pos = SPW'(sp); w.eop = e; w.eop_pos = EPW'(ep); w.off = OW'(off);
        return w;
    endfunction

    function automatic logic [DW-1:0] tx_ctrl();
        return DW'({tx_sop_pos, tx_eop_pos, tx_sop, tx_eop, tx_offset, tx_port});
    endfunction

    function automatic int tx_port_at(input int i);
        return (tx_ports.size() > i) ? tx_ports[i] : -1;
    endfunction

    function automatic int tx_off_at(input int i);
        return (tx_offs.size() > i) ? tx_offs[i] : -1;
    endfunction

    // Random FLU stream: packets of 1..n words, sometimes a new packet starts inside an EOP word
    task automatic gen_stream(input int p, input int n);
        bit open = 1'b0;
        for (int i = 0; i < n || open; i++) begin
            word_t w;
            int sp, ep;
            if (!open) begin
                sp = $urandom_range(0, 7);
                if ($urandom_range(0, 2) == 0) begin
                    ep = $urandom_range(sp*8, 63);
                    w = mk(1'b1, sp, 1'b1, ep, $urandom_range(0, 1023));
                end else begin
                    w = mk(1'b1, sp, 1'b0, $urandom_range(0, 63), $urandom_range(0, 1023));
                    open = 1'b1;
                end
            end else if ($urandom_range(0, 2) == 0 || i >= n) begin
                ep = $urandom_range(0, 63);
                if (i < n && ep < 56 && $urandom_range(0, 1) == 1) begin
                    sp = $urandom_range(ep/8 + 1, 7);
                    w = mk(1'b1, sp, 1'b1, ep, $urandom_range(0, 1023));
                end else begin
                    w = mk(1'b0, $urandom_range(0, 7), 1'b1, ep, $urandom_range(0, 1023));
                    open = 1'b0;
                end
            end else begin
                w = mk(1'b0, $urandom_range(0, 7), 1'b0, $urandom_range(0, 63), $urandom_range(0, 1023));
            end
            src_q[p].push_back(w);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            if (rand_en) en[p] = ($urandom_range(0, 4) != 0);
            if (en[p] && src_q[p].size() > 0) begin
                word_t w = src_q[p][0];
                rx_data[p] = w.data; rx_sop_pos[p] = w.sop_pos; rx_eop_pos[p] = w.eop_pos;
                rx_sop[p] = w.sop; rx_eop[p] = w.eop; rx_off[p] = w.off;
                rx_src_rdy[p] = 1'b1;
            end else begin
                rx_src_rdy[p] = 1'b0;
            end
        end
        tx_dst_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic check_tx();
        int p = int'(tx_port);
        word_t e;
        out_cnt[p]++;
        tx_ports.push_back(p);
        tx_offs.push_back(int'(tx_offset));
        chk("tx_word_expected", DW'(sb_q[p].size() > 0), DW'(1));
        if (sb_q[p].size() > 0) begin
            e = sb_q[p].pop_front();
            chk("tx_data", tx_data, e.data);
            chk("tx_flags", DW'({tx_sop_pos, tx_eop_pos, tx_sop, tx_eop}),
                DW'({e.sop_pos, e.eop_pos, e.sop, e.eop}));
            chk("tx_offset", DW'(tx_offset), DW'(e.off));
            if (tx_open >= 0) chk("tx_contiguous_port", DW'(p), DW'(tx_open));
            if (e.eop && !(e.sop && int'(e.sop_pos)*8 > int'(e.eop_pos))) tx_open = -1;
            else if (e.sop) tx_open = p;
        end
    endtask

    // One clock: drive at posedge+1, observe and account at negedge
    task automatic step();
        drive();
        @(negedge clk);
        if (rst) begin
            chk("rst_tx_src_rdy", DW'(tx_src_rdy), DW'(0));
            chk("rst_dst_rdy0", DW'(rx_dst_rdy[0]), DW'(0));
            chk("rst_dst_rdy1", DW'(rx_dst_rdy[1]), DW'(0));
            sb_q[0].delete(); sb_q[1].delete();
            pend_valid = 1'b0; prev_stall = 1'b0; tx_open = -1; post_rst = 1'b1;
        end else begin
            if (post_rst) begin
                chk("post_rst_tx_src_rdy", DW'(tx_src_rdy), DW'(0));
                chk("post_rst_dst_rdy", DW'({rx_dst_rdy[1], rx_dst_rdy[0]}), DW'(0));
                chk("post_rst_tx_offset", DW'(tx_offset), DW'(0));
                chk("post_rst_tx_port", DW'(tx_port), DW'(0));
                post_rst = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_hold_data", tx_data, snap_data);
                chk("stall_hold_ctrl", tx_ctrl(), snap_ctrl);
                chk("stall_hold_valid", DW'(tx_src_rdy), DW'(1));
            end
            if (pend_valid) begin
                chk("latency_src_rdy", DW'(tx_src_rdy), DW'(1));
                chk("latency_port", DW'(tx_port), DW'(pend_port));
            end
            chk("dst_rdy_exclusive", DW'(rx_dst_rdy[0] & rx_dst_rdy[1]), DW'(0));
            if (tx_src_rdy && tx_dst_rdy) check_tx();
            pend_valid = 1'b0;
            for (int p = 0; p < 2; p++) begin
                if (rx_src_rdy[p] && rx_dst_rdy[p]) begin
                    word_t w = src_q[p].pop_front();
                    if (w.sop) last_off[p] = w.off;
                    w.off = last_off[p];
                    sb_q[p].push_back(w);
                    in_cnt[p]++;
                    pend_valid = 1'b1;
                    pend_port  = p;
                end
            end
            prev_stall = tx_src_rdy && !tx_dst_rdy;
            snap_data  = tx_data;
            snap_ctrl  = tx_ctrl();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until(input int n, input int bound);
        for (int i = 0; i < bound && tx_ports.size() < n; i++) step();
    endtask

    task automatic check_ports(input string tag, input int exp[$]);
        chk({tag, "_count"}, DW'(tx_ports.size()), DW'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s_port%0d", tag, i), DW'(tx_port_at(i)), DW'(exp[i]));
    endtask

    initial begin
        int exp_q[$];
        int n0, n1;
        rst = 1'b1; tx_dst_rdy = 1'b1;
        for (int p = 0; p < 2; p++) begin
            rx_data[p] = '0; rx_sop_pos[p] = '0; rx_eop_pos[p] = '0; rx_sop[p] = 1'b0;
            rx_eop[p] = 1'b0; rx_src_rdy[p] = 1'b0; rx_off[p] = '0; en[p] = 1'b1;
            last_off[p] = '0; in_cnt[p] = 0; out_cnt[p] = 0;
        end

        // Reset state
        step(); step();
        rst = 1'b0;
        step();

        // Tie after reset goes to port 0, then alternation
        tx_ports.delete(); tx_offs.delete();
        src_q[0].push_back(mk(1'b1, 0, 1'b1, 63, 'h101));
        src_q[0].push_back(mk(1'b1, 0, 1'b1, 63, 'h102));
        src_q[1].push_back(mk(1'b1, 0, 1'b1, 63, 'h201));
        src_q[1].push_back(mk(1'b1, 0, 1'b1, 63, 'h202));
        run_until(4, 60);
        exp_q = '{0, 1, 0, 1};
        check_ports("alt", exp_q);
        chk("alt_off0", DW'(tx_off_at(0)), DW'('h101));
        chk("alt_off3", DW'(tx_off_at(3)), DW'('h202));

        // Multi-word packet keeps the lock while the other port waits
        tx_ports.delete(); tx_offs.delete();
        src_q[0].push_back(mk(1'b1, 0, 1'b0, 0, 'h155));
        src_q[0].push_back(mk(1'b0, 0, 1'b0, 0, 'h3FF));
        src_q[0].push_back(mk(1'b0, 0, 1'b1, 63, 'h3FF));
        src_q[1].push_back(mk(1'b1, 0, 1'b1, 63, 'h0AB));
        run_until(4, 60);
        exp_q = '{0, 0, 0, 1};
        check_ports("lock3", exp_q);
        for (int i = 0; i < 3; i++) chk($sformatf("lock3_off%0d", i), DW'(tx_off_at(i)), DW'('h155));

        // EOP word starting a new packet keeps LOCK0; SOP_POS*8 == EOP_POS releases
        tx_ports.delete(); tx_offs.delete();
        src_q[0].push_back(mk(1'b1, 0, 1'b0, 10, 'h011));
        src_q[0].push_back(mk(1'b1, 4, 1'b1, 15, 'h2AA));
        src_q[0].push_back(mk(1'b0, 0, 1'b1, 63, 'h3FF));
        src_q[0].push_back(mk(1'b1, 0, 1'b1, 63, 'h0CC));
        src_q[1].push_back(mk(1'b1, 3, 1'b1, 24, 'h077));
        run_until(5, 80);
        exp_q = '{0, 0, 0, 1, 0};
        check_ports("chain", exp_q);
        chk("chain_off1", DW'(tx_off_at(1)), DW'('h2AA));
        chk("chain_off2", DW'(tx_off_at(2)), DW'('h2AA));
        chk("chain_off4", DW'(tx_off_at(4)), DW'('h0CC));

        // Random traffic with random back-pressure and source gaps
        for (int p = 0; p < 2; p++) begin in_cnt[p] = 0; out_cnt[p] = 0; end
        gen_stream(0, 60);
        gen_stream(1, 60);
        n0 = src_q[0].size(); n1 = src_q[1].size();
        rand_en = 1'b1; rand_rdy = 1'b1;
        for (int i = 0; i < 8000; i++) begin
            if (src_q[0].size() == 0 && src_q[1].size() == 0 &&
                sb_q[0].size() == 0 && sb_q[1].size() == 0) break;
            step();
        end
        rand_en = 1'b0; rand_rdy = 1'b0; en[0] = 1'b1; en[1] = 1'b1;
        chk("rand_in0", DW'(in_cnt[0]), DW'(n0));
        chk("rand_in1", DW'(in_cnt[1]), DW'(n1));
        chk("rand_out0", DW'(out_cnt[0]), DW'(n0));
        chk("rand_out1", DW'(out_cnt[1]), DW'(n1));
        step(); step();

        // Reset in the middle of a 4-word packet on port 1
        src_q[1].push_back(mk(1'b1, 0, 1'b0, 0, 'h111));
        src_q[1].push_back(mk(1'b0, 0, 1'b0, 0, 'h000));
        src_q[1].push_back(mk(1'b0, 0, 1'b0, 0, 'h000));
        src_q[1].push_back(mk(1'b0, 0, 1'b1, 63, 'h000));
        for (int i = 0; i < 40 && src_q[1].size() > 2; i++) step();
        chk("mid_rst_progress", DW'(src_q[1].size()), DW'(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("orphan_dst_rdy1", DW'(rx_dst_rdy[1]), DW'(0));
            chk("orphan_tx_idle", DW'(tx_src_rdy), DW'(0));
        end
        src_q[1].delete();
        tx_ports.delete(); tx_offs.delete();
        src_q[0].push_back(mk(1'b1, 0, 1'b1, 63, 'h0EE));
        run_until(1, 30);
        exp_q = '{0};
        check_ports("after_rst", exp_q);
        chk("after_rst_off", DW'(tx_off_at(0)), DW'('h0EE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
